// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: machine width, NOP encoding, major opcodes and fetch FSM states.
// Single-cycle combinational helpers only; no state or flow control lives here.
package instr_fetch_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPCODE_L = 7'b000_0011;
   localparam logic [6:0] OPCODE_S = 7'b010_0011;
   localparam logic [6:0] OPCODE_I = 7'b001_0011;
   localparam logic [6:0] OPCODE_B = 7'b110_0011;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_OUT   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: PC, memory req/ack, instruction handoff to decode; 0-wait memory gives InstrValid one cycle after MemReq.
// Decode stalls hold the instruction and suppress new requests; a redirect squashes output and drains any in-flight read.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instruction,
   output logic [31:0] InstrPC,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         valid_q, valid_d;
   logic [31:0]  redirect_pc;
   logic         mem_req;
   logic         unused_redirect_lsb;

   assign redirect_pc         = word_align(RedirectPC);
   assign unused_redirect_lsb = ^RedirectPC[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      mem_req    = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (Redirect) begin
               pc_d = redirect_pc;
               // An ack in the redirect cycle closes the old read, so the new one can issue at once.
               if (MemAck) begin
                  req_addr_d = redirect_pc;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (MemAck) begin
               instr_d    = MemRData;
               instr_pc_d = req_addr_q;
               valid_d    = 1'b1;
               pc_d       = req_addr_q + 32'd4;
               state_d    = ST_OUT;
            end
         end

         ST_OUT: begin
            if (Redirect) begin
               valid_d    = 1'b0;
               pc_d       = redirect_pc;
               req_addr_d = redirect_pc;
               state_d    = ST_FETCH;
            end else if (InstrReady) begin
               valid_d    = 1'b0;
               req_addr_d = pc_q;
               state_d    = ST_FETCH;
            end
         end

         ST_DRAIN: begin
            // Memory cannot cancel a read, so the stale address stays up until its ack.
            mem_req = 1'b1;
            if (Redirect) begin
               pc_d = redirect_pc;
               if (MemAck) begin
                  req_addr_d = redirect_pc;
                  state_d    = ST_FETCH;
               end
            end else if (MemAck) begin
               req_addr_d = pc_q;
               state_d    = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign MemReq      = mem_req;
   assign MemAddr     = req_addr_q;
   assign InstrValid  = valid_q & ~Redirect;
   assign Instruction = instr_q;
   assign InstrPC     = instr_pc_q;

   a_no_ack_while_idle: assert property (@(posedge clk) disable iff (reset)
      !(MemAck && (state_q == ST_OUT)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder with programmable wait states, program-order model and literal checks.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        reset2;
   logic        mem_req2;
   logic [31:0] mem_addr2;
   logic        mem_ack2;
   logic [31:0] mem_rdata2;
   logic        instr_valid2;
   logic        instr_ready2;
   logic [31:0] instruction2;
   logic [31:0] instr_pc2;
   logic        redirect2;
   logic [31:0] redirect_pc2;

   int total = 0;
   int bad   = 0;
   int lat   = 0;
   int wait_cnt = 0;

   instr_fetch dut (
      .clk(clk), .reset(reset),
      .MemReq(mem_req), .MemAddr(mem_addr), .MemAck(mem_ack), .MemRData(mem_rdata),
      .InstrValid(instr_valid), .InstrReady(instr_ready),
      .Instruction(instruction), .InstrPC(instr_pc),
      .Redirect(redirect), .RedirectPC(redirect_pc)
   );

   instr_fetch #(.RESET_PC(32'h0000_1000)) dut2 (
      .clk(clk), .reset(reset2),
      .MemReq(mem_req2), .MemAddr(mem_addr2), .MemAck(mem_ack2), .MemRData(mem_rdata2),
      .InstrValid(instr_valid2), .InstrReady(instr_ready2),
      .Instruction(instruction2), .InstrPC(instr_pc2),
      .Redirect(redirect2), .RedirectPC(redirect_pc2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         32'h0000_0008: return 32'h0020_81B3;
         default:       return a ^ 32'h1357_9BDF;
      endcase
   endfunction

   // Memory: acknowledges after `lat` wait cycles of a held request.
   assign mem_ack   = mem_req && (wait_cnt >= lat);
   assign mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Program-order model: the next instruction handed to decode must be the one at exp_pc.
   logic [31:0] exp_pc = 32'h0;
   logic        have_prev = 1'b0;
   logic        prev_req, prev_ack;
   logic [31:0] prev_addr;

   always @(negedge clk) begin
      if (reset) begin
         exp_pc    = 32'h0;
         have_prev = 1'b0;
      end else begin
         if (instr_valid) begin
            chk("model_pc", instr_pc, exp_pc);
            chk("model_insn", instruction, mem_word(instr_pc));
            chk("model_noreq", {31'd0, mem_req}, 32'd0);
         end
         if (mem_req) chk("model_align", {30'd0, mem_addr[1:0]}, 32'd0);
         if (have_prev && prev_req && !prev_ack && mem_req)
            chk("model_addr_hold", mem_addr, prev_addr);
         if (redirect)                        exp_pc = {redirect_pc[31:2], 2'b00};
         else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
         prev_req  = mem_req;
         prev_ack  = mem_ack;
         prev_addr = mem_addr;
         have_prev = 1'b1;
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   logic [31:0] prog [3];

   initial begin
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h00A0_0113;
      prog[2] = 32'h0020_81B3;
      reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; lat = 0;
      reset2 = 1'b1; mem_ack2 = 1'b0; mem_rdata2 = '0; instr_ready2 = 1'b1;
      redirect2 = 1'b0; redirect_pc2 = '0;
      repeat (2) cyc();
      reset = 1'b0;

      // Zero-wait stream from 0,4,8; decode stalls on the third
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("t1_req", {31'd0, mem_req}, 32'd1);
         chk("t1_addr", mem_addr, 32'(4 * i));
         chk("t1_valid_lo", {31'd0, instr_valid}, 32'd0);
         if (i == 0) begin
            chk("rst_insn", instruction, 32'h0000_0013);
            chk("rst_pc", instr_pc, 32'h0);
         end
         cyc();
         if (i == 2) instr_ready = 1'b0;
         #2;
         chk("t1_valid", {31'd0, instr_valid}, 32'd1);
         chk("t1_pc", instr_pc, 32'(4 * i));
         chk("t1_insn", instruction, prog[i]);
         if (i < 2) cyc();
      end

      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t2_valid", {31'd0, instr_valid}, 32'd1);
         chk("t2_pc", instr_pc, 32'h8);
         chk("t2_insn", instruction, 32'h0020_81B3);
         chk("t2_req", {31'd0, mem_req}, 32'd0);
         cyc();
      end

      // Redirect out of OUT back to 0x8, then three wait states
      redirect = 1'b1; redirect_pc = 32'h8; instr_ready = 1'b1; lat = 3;
      #2 chk("t5_squash", {31'd0, instr_valid}, 32'd0);
      cyc();
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("t3_req", {31'd0, mem_req}, 32'd1);
         chk("t3_addr", mem_addr, 32'h8);
         chk("t3_valid", {31'd0, instr_valid}, 32'd0);
         cyc();
      end
      #2 chk("t3_ackcyc_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      #2;
      chk("t3_out_valid", {31'd0, instr_valid}, 32'd1);
      chk("t3_out_pc", instr_pc, 32'h8);
      chk("t3_out_insn", instruction, 32'h0020_81B3);
      lat = 99;
      cyc();

      // Redirect while the read of 0xC is outstanding
      #2 chk("t4_addr", mem_addr, 32'hC);
      cyc();
      redirect = 1'b1; redirect_pc = 32'h101;
      #2 chk("t4_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      redirect = 1'b0; lat = 0;
      #2;
      chk("t4_drain_req", {31'd0, mem_req}, 32'd1);
      chk("t4_drain_addr", mem_addr, 32'hC);
      chk("t4_drain_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      #2;
      chk("t4_new_addr", mem_addr, 32'h100);
      chk("t4_new_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      #2;
      chk("t4_out_pc", instr_pc, 32'h100);
      chk("t4_out_insn", instruction, 32'h1357_9ADF);

      // Redirect to 0x40 while decode is ready
      redirect = 1'b1; redirect_pc = 32'h40;
      #1 chk("t5_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      redirect = 1'b0;
      #2 chk("t5_addr", mem_addr, 32'h40);
      cyc();
      #2 chk("t5_pc", instr_pc, 32'h40);
      cyc();

      // Redirect coinciding with an ack, then PC wrap
      #2 chk("wrap_pre_addr", mem_addr, 32'h44);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      cyc();
      redirect = 1'b0;
      #2 chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      cyc();
      #2;
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_insn", instruction, 32'hECA8_6423);
      cyc();
      #2 chk("wrap_next_addr", mem_addr, 32'h0);
      cyc();
      #2;
      chk("wrap_next_pc", instr_pc, 32'h0);
      chk("wrap_next_insn", instruction, 32'h0050_0093);
      cyc();

      // Repeated redirects during drain: latest target wins
      #2 chk("drn_addr0", mem_addr, 32'h4);
      lat = 99; redirect = 1'b1; redirect_pc = 32'h200;
      cyc();
      redirect_pc = 32'h300;
      #2;
      chk("drn_addr1", mem_addr, 32'h4);
      chk("drn_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
      redirect_pc = 32'h400; lat = 0;
      #2 chk("drn_addr2", mem_addr, 32'h4);
      cyc();
      redirect = 1'b0;
      #2 chk("drn_new_addr", mem_addr, 32'h400);
      cyc();
      #2;
      chk("drn_out_pc", instr_pc, 32'h400);
      chk("drn_out_insn", instruction, 32'h1357_9FDF);

      // Second instance: RESET_PC=0x1000, reset asserted while fetching
      cyc();
      reset2 = 1'b0;
      #2;
      chk("t6_rst_req", {31'd0, mem_req2}, 32'd1);
      chk("t6_rst_addr", mem_addr2, 32'h1000);
      chk("t6_rst_valid", {31'd0, instr_valid2}, 32'd0);
      chk("t6_rst_insn", instruction2, 32'h0000_0013);
      mem_ack2 = 1'b1; mem_rdata2 = 32'h1234_5678;
      cyc();
      mem_ack2 = 1'b0;
      #2;
      chk("t6_valid", {31'd0, instr_valid2}, 32'd1);
      chk("t6_insn", instruction2, 32'h1234_5678);
      chk("t6_pc", instr_pc2, 32'h1000);
      cyc();
      #2 chk("t6_fetch_addr", mem_addr2, 32'h1004);
      reset2 = 1'b1;
      cyc();
      reset2 = 1'b0;
      #2;
      chk("t6_mid_req", {31'd0, mem_req2}, 32'd1);
      chk("t6_mid_addr", mem_addr2, 32'h1000);
      chk("t6_mid_valid", {31'd0, instr_valid2}, 32'd0);
      chk("t6_mid_insn", instruction2, 32'h0000_0013);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
